// File: rtl/iter_pow_unit.sv
// iter_pow_unit
//   Handshaked multi-cycle evaluator. Each command computes one of:
//     power mode (in_mode=0): in_a ** in_exp, by square-and-multiply,
//                             consuming one exponent bit per cycle.
//     sum mode   (in_mode=1): in_a + in_b + 1.
//   Results wrap modulo 2^WIDTH. out_overflow reports that the true result
//   did not fit in WIDTH bits.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   command handshake; in_ready is high only when idle
//   in_mode             0 = power, 1 = sum
//   in_a, in_b, in_exp  operands (unsigned)
//   out_valid/out_ready result handshake
//   out_result          result modulo 2^WIDTH
//   out_overflow        true result needed more than WIDTH bits
module iter_pow_unit #(
  parameter int WIDTH = 32,
  parameter int EXP_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [EXP_W-1:0] in_exp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_overflow
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [WIDTH-1:0] ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sq_q, sq_d;
  logic [EXP_W-1:0] e_q, e_d;
  logic             ovf_q, ovf_d;
  // Output registers are separate from acc so the presented result only
  // changes on the edge that enters DONE.
  logic [WIDTH-1:0] res_q, res_d;
  logic             of_q, of_d;

  // Two full-width multipliers: accumulate and square.
  logic [2*WIDTH-1:0] prod_acc;
  logic [2*WIDTH-1:0] prod_sq;
  logic [EXP_W-1:0]   e_sh;
  logic [WIDTH-1:0]   acc_nxt;
  logic               ovf_nxt;
  logic [WIDTH:0]     sum_full;

  always_comb begin
    prod_acc = acc_q * sq_q;
    prod_sq  = sq_q * sq_q;
    e_sh     = e_q >> 1;
    acc_nxt  = e_q[0] ? prod_acc[WIDTH-1:0] : acc_q;
    // A wrapped square only matters if a later exponent bit will use it.
    ovf_nxt  = ovf_q
             | (e_q[0] & (|prod_acc[2*WIDTH-1:WIDTH]))
             | ((e_sh != '0) & (|prod_sq[2*WIDTH-1:WIDTH]));
    sum_full = {1'b0, in_a} + {1'b0, in_b} + {{WIDTH{1'b0}}, 1'b1};
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    sq_d    = sq_q;
    e_d     = e_q;
    ovf_d   = ovf_q;
    res_d   = res_q;
    of_d    = of_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          ovf_d = 1'b0;
          if (in_mode) begin
            res_d   = sum_full[WIDTH-1:0];
            of_d    = sum_full[WIDTH];
            state_d = S_DONE;
          end else if (in_exp == '0) begin
            res_d   = ONE_W;
            of_d    = 1'b0;
            state_d = S_DONE;
          end else begin
            acc_d   = ONE_W;
            sq_d    = in_a;
            e_d     = in_exp;
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        acc_d = acc_nxt;
        sq_d  = prod_sq[WIDTH-1:0];
        e_d   = e_sh;
        ovf_d = ovf_nxt;
        if (e_sh == '0) begin
          res_d   = acc_nxt;
          of_d    = ovf_nxt;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      sq_q    <= '0;
      e_q     <= '0;
      ovf_q   <= 1'b0;
      res_q   <= '0;
      of_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      sq_q    <= sq_d;
      e_q     <= e_d;
      ovf_q   <= ovf_d;
      res_q   <= res_d;
      of_q    <= of_d;
    end
  end

  assign in_ready     = (state_q == S_IDLE);
  assign out_valid    = (state_q == S_DONE);
  assign out_result   = res_q;
  assign out_overflow = of_q;

endmodule

// File: tb/tb_iter_pow_unit.sv
// Bench for iter_pow_unit. A 32-bit and an 8-bit instance share one command
// stream and run in lockstep (latency depends only on the exponent), so each
// command checks both widths.
module tb_iter_pow_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_mode = 1'b0;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic [4:0]  in_exp = '0;
  logic        out_ready = 1'b0;

  logic        rdy32, ov32, of32;
  logic [31:0] res32;
  logic        rdy8, ov8, of8;
  logic [7:0]  res8;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  iter_pow_unit #(.WIDTH(32), .EXP_W(5)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy32),
    .in_mode(in_mode), .in_a(in_a), .in_b(in_b), .in_exp(in_exp),
    .out_valid(ov32), .out_ready(out_ready), .out_result(res32),
    .out_overflow(of32));

  iter_pow_unit #(.WIDTH(8), .EXP_W(5)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy8),
    .in_mode(in_mode), .in_a(in_a[7:0]), .in_b(in_b[7:0]), .in_exp(in_exp),
    .out_valid(ov8), .out_ready(out_ready), .out_result(res8),
    .out_overflow(of8));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: repeated multiplication on plain integers; overflow is
  // "some partial product of the true power reached 2^w".
  function automatic void model(input bit mode, input logic [31:0] a, input logic [31:0] b,
                                input logic [4:0] e, input int w,
                                output logic [31:0] r, output bit of);
    longint unsigned mask, aa, p;
    mask = (64'd1 << w) - 1;
    aa   = a & mask;
    if (mode) begin
      p  = aa + (b & mask) + 1;
      of = (p > mask);
      r  = 32'(p & mask);
    end else begin
      p  = 1;
      of = 1'b0;
      for (int i = 0; i < int'(e); i++) begin
        p = p * aa;
        if (p > mask) of = 1'b1;
        p = p & mask;
      end
      r = 32'(p);
    end
  endfunction

  function automatic int exp_lat(input bit mode, input logic [4:0] e);
    int l = 0;
    if (mode || e == 0) return 1;
    for (int i = 0; i < 5; i++) if (e[i]) l = i + 1;
    return 1 + l;
  endfunction

  // Issue one command from a negedge, check latency, result and retire.
  task automatic run_cmd(input string nm, input bit mode, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] e, input int hold,
                         input logic [31:0] x32, input bit xo32,
                         input logic [7:0] x8, input bit xo8);
    int n = 0;
    int lat;
    logic [31:0] h32;
    logic [7:0]  h8;
    while (!(rdy32 && rdy8) && n < 50) begin @(negedge clk); n++; end
    chk({nm, " in_ready"}, {62'd0, rdy32, rdy8}, 64'd3);
    in_valid = 1'b1; in_mode = mode; in_a = a; in_b = b; in_exp = e;
    @(posedge clk);
    @(negedge clk);
    // Scrambled operands stay valid while busy; they must be ignored.
    in_mode = ~mode; in_a = ~a; in_b = ~b; in_exp = ~e;
    lat = 1;
    while (!ov32 && lat < 100) begin @(negedge clk); lat++; end
    chk({nm, " latency"}, 64'(lat), 64'(exp_lat(mode, e)));
    chk({nm, " ov8"}, {63'd0, ov8}, 64'd1);
    chk({nm, " res32"}, {32'd0, res32}, {32'd0, x32});
    chk({nm, " of32"}, {63'd0, of32}, {63'd0, xo32});
    chk({nm, " res8"}, {56'd0, res8}, {56'd0, x8});
    chk({nm, " of8"}, {63'd0, of8}, {63'd0, xo8});
    h32 = res32; h8 = res8;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({nm, " hold"}, {res32, res8, of32, of8, ov32, ov8, rdy32, rdy8},
          {h32, h8, xo32, xo8, 1'b1, 1'b1, 1'b0, 1'b0});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({nm, " retire"}, {60'd0, ov32, ov8, rdy32, rdy8}, 64'b0011);
  endtask

  typedef struct {
    string       nm;
    bit          mode;
    logic [31:0] a, b;
    logic [4:0]  e;
    int          hold;
    logic [31:0] x32;
    bit          xo32;
    logic [7:0]  x8;
    bit          xo8;
  } vec_t;

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{"pow2^4",     1'b0, 32'd2,        32'd0,        5'd4,  5, 32'd16,         1'b0, 8'd16,  1'b0};
    vecs[1]  = '{"sum1+2",     1'b1, 32'd1,        32'd2,        5'd0,  0, 32'd4,          1'b0, 8'd4,   1'b0};
    vecs[2]  = '{"sum255+0",   1'b1, 32'd255,      32'd0,        5'd0,  0, 32'd256,        1'b0, 8'd0,   1'b1};
    vecs[3]  = '{"pow0^0",     1'b0, 32'd0,        32'd0,        5'd0,  1, 32'd1,          1'b0, 8'd1,   1'b0};
    vecs[4]  = '{"pow2^8",     1'b0, 32'd2,        32'd0,        5'd8,  0, 32'd256,        1'b0, 8'd0,   1'b1};
    vecs[5]  = '{"pow16^1",    1'b0, 32'd16,       32'd0,        5'd1,  0, 32'd16,         1'b0, 8'd16,  1'b0};
    vecs[6]  = '{"pow3^5",     1'b0, 32'd3,        32'd0,        5'd5,  2, 32'd243,        1'b0, 8'd243, 1'b0};
    vecs[7]  = '{"sum_max",    1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0,  0, 32'hFFFFFFFF,   1'b1, 8'hFF,  1'b1};
    vecs[8]  = '{"pow2^31",    1'b0, 32'd2,        32'd0,        5'd31, 0, 32'h80000000,   1'b0, 8'd0,   1'b1};
    vecs[9]  = '{"pow0^5",     1'b0, 32'd0,        32'd0,        5'd5,  0, 32'd0,          1'b0, 8'd0,   1'b0};
    vecs[10] = '{"pow65536^2", 1'b0, 32'h10000,    32'd0,        5'd2,  0, 32'd0,          1'b1, 8'd0,   1'b0};
    vecs[11] = '{"pow255^2",   1'b0, 32'd255,      32'd0,        5'd2,  0, 32'd65025,      1'b0, 8'd1,   1'b1};

    // Reset state
    #12;
    chk("reset32", {res32, of32, ov32, rdy32}, {32'd0, 1'b0, 1'b0, 1'b1});
    chk("reset8", {56'd0, res8, of8, ov8, rdy8}, {56'd0, 8'd0, 1'b0, 1'b0, 1'b1});
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++)
      run_cmd(vecs[i].nm, vecs[i].mode, vecs[i].a, vecs[i].b, vecs[i].e, vecs[i].hold,
              vecs[i].x32, vecs[i].xo32, vecs[i].x8, vecs[i].xo8);

    // Random stream with bursty out_ready and idle gaps.
    for (int i = 0; i < 20; i++) begin
      bit          m;
      logic [31:0] a, b, r32, r8;
      logic [4:0]  e;
      bit          o32, o8;
      m = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 20));
      b = $urandom;
      e = 5'($urandom_range(0, 31));
      model(m, a, b, e, 32, r32, o32);
      model(m, a, b, e, 8, r8, o8);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_cmd($sformatf("rand%0d", i), m, a, b, e, $urandom_range(0, 3),
              r32, o32, r8[7:0], o8);
    end

    // Reset during RUN of 5**7 aborts the command.
    in_valid = 1'b1; in_mode = 1'b0; in_a = 32'd5; in_b = 32'd0; in_exp = 5'd7;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("mid_run_busy", {62'd0, rdy32, ov32}, 64'd0);
    rst_n = 1'b0;
    #1;
    chk("abort32", {res32, ov32, rdy32}, {32'd0, 1'b0, 1'b1});
    chk("abort8", {54'd0, res8, ov8, rdy8}, {54'd0, 8'd0, 1'b0, 1'b1});
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("no_stale", {62'd0, ov32, ov8}, 64'd0);
    end
    run_cmd("sum2+2", 1'b1, 32'd2, 32'd2, 5'd0, 0, 32'd5, 1'b0, 8'd5, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/iter_pow_unit.md
# iter_pow_unit

Multi-cycle integer evaluation unit that computes either `base ** exp` (square-and-multiply, one exponent bit per cycle) or `a + b + 1` on a WIDTH-bit datapath. It replaces fixed-width, elaboration-time function evaluation with a run-time, handshaked unit, and sits between a command source and a result consumer. Both sides use valid/ready handshakes. Results wrap modulo 2^WIDTH, and an overflow flag reports any lost bits.

## Interface
- `WIDTH`, 32: operand and result width in bits (≥ 2).
- `EXP_W`, 5: exponent width in bits (≥ 1).

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  command valid.
- `in_ready`  out  1  unit can accept a command.
- `in_mode`  in  1  0 = power, 1 = sum.
- `in_a`  in  WIDTH  power mode: base; sum mode: first addend (unsigned).
- `in_b`  in  WIDTH  sum mode: second addend; ignored in power mode.
- `in_exp`  in  EXP_W  power mode: exponent (unsigned); ignored in sum mode.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts the result.
- `out_result`  out  WIDTH  result modulo 2^WIDTH.
- `out_overflow`  out  1  true result did not fit in WIDTH bits.

## Operation
- FSM states:
  - IDLE: `in_ready`=1.
  - RUN: iterating.
  - DONE: `out_valid`=1.
- Accept: occurs when `in_valid && in_ready`. Operands are captured and must not be re-sampled afterwards.
- Accept in sum mode:
  - `result = a + b + 1` over WIDTH+1 bits.
  - `out_result` = low WIDTH bits; `out_overflow` = bit WIDTH.
  - Next state: DONE.
- Accept in power mode with `exp == 0`: `result = 1`, `overflow = 0`. Next state: DONE. This includes `0 ** 0 = 1`.
- Accept in power mode with `exp != 0`: `acc = 1`, `sq = base`, `e = exp`, `ovf = 0`. Next state: RUN.
- RUN, per cycle:
  - If `e[0]`: `acc ← (acc * sq) mod 2^WIDTH`. `ovf` is set if the full 2·WIDTH product ≥ 2^WIDTH.
  - Then `sq ← (sq * sq) mod 2^WIDTH`. `ovf` is set if that square overflowed **and** `(e >> 1) != 0`. A squared value that is never used must not flag.
  - `e ← e >> 1`. If the new `e == 0`, the next state is DONE.
- `ovf` is sticky for the current command and is cleared on the next accept.
- DONE: `out_result` and `out_overflow` are held stable while `out_valid && !out_ready`. When `out_ready` is high, the next state is IDLE.
- `in_ready` is high only in IDLE. There is no accept in the cycle that DONE retires: one bubble per command.
- Asynchronous reset drives state to IDLE. Reset values: `in_ready`=1, `out_valid`=0, `out_result`=0, `out_overflow`=0. All internal registers are cleared.
- Reset asserted mid-RUN or in DONE aborts the command. No result is ever presented for it.
- `in_valid` while busy is ignored; the source holds the command until `in_ready`.
- Inputs are unsigned throughout. Negative or signed interpretation is not supported.

## Timing
- Accept at edge T. Let L = bitlen(exp), the index of the highest set bit plus 1; L ≤ EXP_W.
- Sum mode, or power with `exp == 0`: `out_valid`=1 from cycle T+1.
- Power with `exp != 0`: RUN lasts exactly L cycles, and `out_valid`=1 from cycle T+1+L.
- Retire at edge R (`out_valid && out_ready`): `out_valid`=0 and `in_ready`=1 from R+1. The earliest next accept is at edge R+1.
- Best-case throughput: one sum command per 2 cycles.
- `out_result` and `out_overflow` may change only on the edge entering DONE.
- Multiplier: single-cycle combinational WIDTH×WIDTH multipliers, two instances (acc and sq). No multicycle paths.

## Test plan
- Power, WIDTH=32: `a=2`, `exp=4` accepted at T → `out_valid` at T+4 (L=3), `out_result=16`, `out_overflow=0`. Hold `out_ready=0` for 5 cycles → result stable and `in_ready=0` throughout.
- Sum: `a=1`, `b=2` → `out_valid` at T+1, `out_result=4`. Then WIDTH=8 with `a=255`, `b=0` → `out_result=0`, `out_overflow=1`.
- Exponent zero: `a=0`, `exp=0` → `out_result=1`, `out_overflow=0`, `out_valid` at T+1.
- Overflow, WIDTH=8:
  - `2**8` → `out_result=0`, `out_overflow=1`.
  - `16**1` → `16`, `overflow=0`. The unused square of 16 must not flag.
  - `3**5` → `243`, `overflow=0`.
- Back-to-back with bursty `out_ready`: stream of 20 random commands compared against a reference model. Check that exactly one result is produced per accept, in order, with latency as specified.
- Reset mid-op: pull `rst_n` low during RUN of `5**7` → `out_valid=0` and `in_ready=1` immediately. After release, a new `2+2+1` command returns `5` and no stale result appears.
